// File: rtl/sort_pkg.sv
// Shared definitions for the frame_sorter block: FSM state encoding and
// width helpers derived from DEPTH.
package sort_pkg;

  // Frame state: loading samples (FILL) or streaming them out (DRAIN).
  typedef enum logic [0:0] {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } state_e;

  // Width of an arrival-position tag; never narrower than one bit.
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a counter that must hold 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/sort_cell.sv
// One position of the sorted register array. Holds a sample, an occupied
// flag and (with FRAME_SORTER_IDX_EN) the sample's arrival tag. The parent
// decides per cycle whether the cell loads the new sample, takes its lower
// neighbour (insert shift-up) or its upper neighbour (drain shift-down).
module sort_cell #(
  parameter int WIDTH = 8
`ifdef FRAME_SORTER_IDX_EN
  , parameter int IDX_W = 2
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             take_new,
  input  logic             shift_up,
  input  logic             pop,
  input  logic [WIDTH-1:0] new_data,
  input  logic [WIDTH-1:0] below_data,
  input  logic             below_occ,
  input  logic [WIDTH-1:0] above_data,
  input  logic             above_occ,
`ifdef FRAME_SORTER_IDX_EN
  input  logic [IDX_W-1:0] new_tag,
  input  logic [IDX_W-1:0] below_tag,
  input  logic [IDX_W-1:0] above_tag,
  output logic [IDX_W-1:0] tag,
`endif
  output logic [WIDTH-1:0] data,
  output logic             occ,
  output logic             gt_new
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             occ_q, occ_d;
`ifdef FRAME_SORTER_IDX_EN
  logic [IDX_W-1:0] tag_q, tag_d;
`endif

  // Insert decision input: an empty cell never counts as greater.
  assign gt_new = occ_q && (data_q > new_data);
  assign data   = data_q;
  assign occ    = occ_q;
`ifdef FRAME_SORTER_IDX_EN
  assign tag    = tag_q;
`endif

  // Next cell contents: drain shift-down, insert here, insert shift-up, or hold.
  always_comb begin
    data_d = data_q;
    occ_d  = occ_q;
`ifdef FRAME_SORTER_IDX_EN
    tag_d  = tag_q;
`endif
    if (pop) begin
      data_d = above_data;
      occ_d  = above_occ;
`ifdef FRAME_SORTER_IDX_EN
      tag_d  = above_tag;
`endif
    end else if (take_new) begin
      data_d = new_data;
      occ_d  = 1'b1;
`ifdef FRAME_SORTER_IDX_EN
      tag_d  = new_tag;
`endif
    end else if (shift_up) begin
      data_d = below_data;
      occ_d  = below_occ;
`ifdef FRAME_SORTER_IDX_EN
      tag_d  = below_tag;
`endif
    end
  end

  // Cell registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      occ_q  <= 1'b0;
`ifdef FRAME_SORTER_IDX_EN
      tag_q  <= '0;
`endif
    end else begin
      data_q <= data_d;
      occ_q  <= occ_d;
`ifdef FRAME_SORTER_IDX_EN
      tag_q  <= tag_d;
`endif
    end
  end

endmodule

// File: rtl/frame_sorter.sv
// Streaming frame sorter: accepts up to DEPTH unsigned samples, keeps them
// sorted by parallel in-place insertion, then streams them out min first.
// Optional macro FRAME_SORTER_IDX_EN adds out_idx, the arrival position of
// each emitted sample within its frame.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid never waits for ready, and data/last are held stable while
// valid is high and ready is low.
module frame_sorter
  import sort_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_last,
`ifdef FRAME_SORTER_IDX_EN
  output logic [idx_width(DEPTH)-1:0] out_idx,
`endif
  output logic [0:0]                  dbg_state
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST_SLOT = CNT_W'(DEPTH - 1);
  localparam logic [0:0] ST_FILL  = FILL;
  localparam logic [0:0] ST_DRAIN = DRAIN;
`ifdef FRAME_SORTER_IDX_EN
  localparam int IDX_W = idx_width(DEPTH);
`endif

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             pop;

  logic [WIDTH-1:0] cell_data [DEPTH];
  logic [DEPTH-1:0] cell_occ;
  logic [DEPTH-1:0] cell_gt;
  logic [DEPTH-1:0] at_or_above;
  logic [DEPTH-1:0] take_new;
  logic [DEPTH-1:0] shift_up;
`ifdef FRAME_SORTER_IDX_EN
  logic [IDX_W-1:0] cell_tag [DEPTH];
  logic [IDX_W-1:0] new_tag;

  // Arrival position of the incoming sample equals samples already held.
  assign new_tag = count_q[IDX_W-1:0];
`endif

  assign accept = in_valid && (state_q == ST_FILL);
  assign pop    = out_ready && (state_q == ST_DRAIN);

  // Per-cell insert control. Occupied cells form a sorted prefix, so the set
  // of cells "greater than new or empty" is a contiguous suffix; its lowest
  // cell takes the new sample and every cell above it takes its lower
  // neighbour. Equal values are not greater, so ties land after old ones.
  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [WIDTH-1:0] below_data_w;
    logic             below_occ_w;
    logic [WIDTH-1:0] above_data_w;
    logic             above_occ_w;
`ifdef FRAME_SORTER_IDX_EN
    logic [IDX_W-1:0] below_tag_w;
    logic [IDX_W-1:0] above_tag_w;
`endif

    assign at_or_above[i] = cell_gt[i] | ~cell_occ[i];

    if (i == 0) begin : g_bottom
      assign take_new[i]  = accept & at_or_above[i];
      assign shift_up[i]  = 1'b0;
      assign below_data_w = '0;
      assign below_occ_w  = 1'b0;
`ifdef FRAME_SORTER_IDX_EN
      assign below_tag_w  = '0;
`endif
    end else begin : g_mid
      assign take_new[i]  = accept & at_or_above[i] & ~at_or_above[i-1];
      assign shift_up[i]  = accept & at_or_above[i-1];
      assign below_data_w = cell_data[i-1];
      assign below_occ_w  = cell_occ[i-1];
`ifdef FRAME_SORTER_IDX_EN
      assign below_tag_w  = cell_tag[i-1];
`endif
    end

    if (i == DEPTH - 1) begin : g_top
      assign above_data_w = '0;
      assign above_occ_w  = 1'b0;
`ifdef FRAME_SORTER_IDX_EN
      assign above_tag_w  = '0;
`endif
    end else begin : g_low
      assign above_data_w = cell_data[i+1];
      assign above_occ_w  = cell_occ[i+1];
`ifdef FRAME_SORTER_IDX_EN
      assign above_tag_w  = cell_tag[i+1];
`endif
    end

    sort_cell #(
      .WIDTH (WIDTH)
`ifdef FRAME_SORTER_IDX_EN
      , .IDX_W (IDX_W)
`endif
    ) u_cell (
      .clk        (clk),
      .rst        (rst),
      .take_new   (take_new[i]),
      .shift_up   (shift_up[i]),
      .pop        (pop),
      .new_data   (in_data),
      .below_data (below_data_w),
      .below_occ  (below_occ_w),
      .above_data (above_data_w),
      .above_occ  (above_occ_w),
`ifdef FRAME_SORTER_IDX_EN
      .new_tag    (new_tag),
      .below_tag  (below_tag_w),
      .above_tag  (above_tag_w),
      .tag        (cell_tag[i]),
`endif
      .data       (cell_data[i]),
      .occ        (cell_occ[i]),
      .gt_new     (cell_gt[i])
    );
  end

  // FSM and sample count: a frame ends on in_last or on the DEPTH-th sample;
  // the drain ends after the pop of the final remaining sample.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    case (state_q)
      ST_FILL: begin
        if (accept) begin
          count_d = count_q + CNT_ONE;
          if (in_last || (count_q == CNT_LAST_SLOT)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      default: begin
        if (pop) begin
          count_d = count_q - CNT_ONE;
          if (count_q == CNT_ONE) begin
            state_d = ST_FILL;
          end
        end
      end
    endcase
  end

  // State and count registers, cleared by asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_FILL;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // Outputs are pure state decodes; data is zero whenever it is not valid.
  assign in_ready  = (state_q == ST_FILL);
  assign out_valid = (state_q == ST_DRAIN);
  assign out_data  = out_valid ? cell_data[0] : '0;
  assign out_last  = out_valid && (count_q == CNT_ONE);
  assign dbg_state = state_q;
`ifdef FRAME_SORTER_IDX_EN
  assign out_idx   = out_valid ? cell_tag[0] : '0;
`endif

endmodule

// File: tb/tb_frame_sorter.sv
// Directed plus light random testbench for frame_sorter (WIDTH=8, DEPTH=4).
// Expected outputs come from a stable insertion-sort reference model filled
// as samples are driven and popped as the DUT emits them.
module tb_frame_sorter;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic [0:0] dbg_state;
`ifdef FRAME_SORTER_IDX_EN
  logic [1:0] out_idx;
`endif

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic       exp_last_q[$];
  logic [1:0] exp_idx_q[$];
  logic [7:0] frame_vals[$];

  frame_sorter #(.WIDTH(8), .DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
`ifdef FRAME_SORTER_IDX_EN
    .out_idx   (out_idx),
`endif
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: stable insertion sort of the frame just sent.
  task automatic finish_frame();
    logic [7:0] sv[$];
    logic [1:0] st[$];
    int pos;
    for (int j = 0; j < frame_vals.size(); j++) begin
      pos = sv.size();
      for (int k = 0; k < sv.size(); k++) begin
        if (pos == sv.size() && sv[k] > frame_vals[j]) pos = k;
      end
      sv.insert(pos, frame_vals[j]);
      st.insert(pos, 2'(j));
    end
    for (int k = 0; k < sv.size(); k++) begin
      exp_q.push_back(sv[k]);
      exp_idx_q.push_back(st[k]);
      exp_last_q.push_back(k == sv.size() - 1);
    end
    frame_vals.delete();
  endtask

  // Driver: present one sample at a negedge, return at the following negedge.
  task automatic send(input logic [7:0] d, input logic l);
    int k = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("send_ready", 32'(in_ready), 32'd1);
    check("fill_out_valid", 32'(out_valid), 32'd0);
    frame_vals.push_back(d);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Consume one expected output and compare against the DUT.
  task automatic compare_pop();
    if (exp_q.size() == 0) begin
      check("spurious_out", 32'(out_valid), 32'd0);
    end else begin
      check("out_data", 32'(out_data), 32'(exp_q[0]));
      check("out_last", 32'(out_last), 32'(exp_last_q[0]));
`ifdef FRAME_SORTER_IDX_EN
      check("out_idx", 32'(out_idx), 32'(exp_idx_q[0]));
`endif
      void'(exp_q.pop_front());
      void'(exp_last_q.pop_front());
      void'(exp_idx_q.pop_front());
    end
  endtask

  // Drain n samples, optionally holding out_ready low for stall_len cycles
  // once stall_after samples have been taken.
  task automatic drain(input int n, input int stall_after, input int stall_len);
    int got = 0;
    int cyc = 0;
    int stall = 0;
    while (got < n && cyc < 200) begin
      if (got == stall_after && stall < stall_len) begin
        out_ready = 1'b0;
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        if (exp_q.size() > 0) begin
          check("stall_data", 32'(out_data), 32'(exp_q[0]));
          check("stall_last", 32'(out_last), 32'(exp_last_q[0]));
        end
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        check("drain_in_ready", 32'(in_ready), 32'd0);
        check("drain_state", 32'(dbg_state), 32'd1);
        compare_pop();
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    check("drain_count", 32'(got), 32'(n));
    out_ready = 1'b1;
  endtask

  initial begin
    int s;
    int got;
    int nready;
    int lasts;
    int cyc;
    int n;
    logic [7:0] stream [7];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Ordering with a full frame (no in_last) and a 3-cycle stall mid-drain
    send(8'h30, 1'b0);
    send(8'h10, 1'b0);
    send(8'h40, 1'b0);
    send(8'h20, 1'b0);
    check("latency_out_valid", 32'(out_valid), 32'd1);
    check("latency_in_ready", 32'(in_ready), 32'd0);
    finish_frame();
    check("order_head", 32'(exp_q[0]), 32'h10);
    drain(4, 2, 3);
    check("post_drain_ready", 32'(in_ready), 32'd1);
    check("post_drain_valid", 32'(out_valid), 32'd0);

    // Stable ties
    send(8'h05, 1'b0);
    send(8'h05, 1'b0);
    send(8'h03, 1'b0);
    send(8'h05, 1'b0);
    finish_frame();
    drain(4, -1, 0);

    // Short frame, unsigned extremes
    send(8'hFF, 1'b0);
    send(8'h00, 1'b1);
    finish_frame();
    drain(2, -1, 0);
    check("short_ready_back", 32'(in_ready), 32'd1);

    // One-sample frame
    send(8'h9A, 1'b1);
    finish_frame();
    drain(1, 0, 1);

    // Reset mid-drain, then a fresh frame
    send(8'h50, 1'b0);
    send(8'h60, 1'b0);
    send(8'h70, 1'b0);
    send(8'h80, 1'b0);
    finish_frame();
    drain(2, -1, 0);
    out_ready = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_ready", 32'(in_ready), 32'd1);
    check("async_rst_last", 32'(out_last), 32'd0);
    #1 rst = 1'b0;
    exp_q.delete(); exp_last_q.delete(); exp_idx_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("after_rst_valid", 32'(out_valid), 32'd0);
    send(8'h07, 1'b0);
    send(8'h01, 1'b0);
    send(8'h04, 1'b0);
    send(8'h02, 1'b0);
    finish_frame();
    drain(4, -1, 0);

    // Back-to-back: frame of 3 ended by in_last, then a full frame of 4
    stream = '{8'h22, 8'h11, 8'h33, 8'hC0, 8'h0C, 8'hC0, 8'h01};
    s = 0; got = 0; nready = 0; lasts = 0; cyc = 0;
    out_ready = 1'b1;
    while ((s < 7 || got < 7) && cyc < 300) begin
      if (out_valid && out_ready) begin
        if (out_last) lasts++;
        compare_pop();
        got++;
      end
      if (in_ready && s < 7) begin
        in_valid = 1'b1;
        in_data  = stream[s];
        in_last  = (s == 2);
        frame_vals.push_back(stream[s]);
        if (s == 2 || s == 6) finish_frame();
        s++;
      end else if (!in_ready) begin
        nready++;
        in_last = 1'b0;
      end else begin
        in_valid = 1'b0;
        in_last  = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("b2b_outputs", 32'(got), 32'd7);
    check("b2b_not_ready_cycles", 32'(nready), 32'd7);
    check("b2b_last_count", 32'(lasts), 32'd2);

    // Random frames
    for (int f = 0; f < 4; f++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        send(8'($urandom_range(0, 255)),
             (j == n - 1) && (n < 4 || $urandom_range(0, 1) == 1));
      end
      finish_frame();
      drain(n, $urandom_range(0, n - 1), $urandom_range(0, 2));
    end
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
